ocm_scanout_reader: RTL and testbench
=====================================

Name: ocm_scanout_reader

Overview:
- Streaming read engine directly upstream of the 64K x 32 single-port on-chip memory.
- On a start pulse it issues sequential word reads from a base address and captures read data one cycle after each issue.
- Captured words pass through a small credit-controlled FIFO to a valid/ready stream consumed by pixel or scanout logic.
- Forms the data path between on-chip memory and the video output side of the SoC.

Parameters:
- ADDR_W, 16, memory word-address width; also the address wrap modulus 2^ADDR_W.
- DATA_W, 32, memory and stream data width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.
- CNT_W, 17, width of word_count; must allow the full 65536-word memory.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address, latched on start.
- word_count  in  CNT_W  number of words to read, latched on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- mem_address  out  ADDR_W  read address to memory.
- mem_clken  out  1  memory clock enable; high when a read is issued.
- mem_readdata  in  DATA_W  memory q, valid the cycle after issue.
- out_data  out  DATA_W  stream data (FIFO head).
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  high with the final word of a transfer.

Behaviour:
- Reset values: busy=0, done=0, mem_address=0, mem_clken=0, out_valid=0, out_last=0, out_data=0. FIFO is empty, no reads are in flight, state=IDLE.
- States:
  - IDLE: on start with word_count!=0, latch base_addr and word_count, then go to RUN. On start with word_count==0, go to FIN with no reads issued.
  - RUN: issue reads until remaining==0, then go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, then go to FIN.
  - FIN: done=1 for one cycle, then go to IDLE.
- Issue rule (RUN):
  - Issue when remaining!=0 and fifo_count + inflight < FIFO_DEPTH, where inflight is 0 or 1.
  - On issue: mem_clken=1 and mem_address=current address (combinational from the address register). Then address increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000) and remaining decrements.
  - Back-to-back issues are allowed, giving 1 word/cycle sustained throughput when out_ready=1.
- Capture: a read issued in cycle N registers inflight_v=1. In cycle N+1, mem_readdata is written into the FIFO. Latency from issue to out_valid is 2 cycles (capture, then FIFO register).
- The credit rule guarantees FIFO overflow is impossible. A simultaneous FIFO push and pop leaves the count unchanged.
- out_last is tagged on the captured word whose issue decremented remaining to 0.
- Stream rule: out_data, out_valid and out_last hold stable while out_valid=1 and out_ready=0. A transfer occurs on out_valid & out_ready.
- start while busy is ignored. base_addr and word_count are not re-sampled during a transfer.
- word_count > 65536 is allowed; addresses simply keep wrapping.
- busy is asserted in RUN, DRAIN and FIN, and deasserts in the cycle after done.
- Asynchronous reset mid-transfer: everything returns to reset values immediately, FIFO contents are discarded, and no done pulse is generated.
- mem_clken=0 whenever no read is issued, so the memory output holds its last value. Capture depends only on inflight_v, never on mem_readdata changing.

Decomposition:
- Shared package ocm_pkg:
  - state enum {IDLE, RUN, DRAIN, FIN}.
  - constants OCM_ADDR_W=16, OCM_DATA_W=32, OCM_DEPTH=65536.
- One sub-module, ocm_stream_fifo:
  - synchronous FIFO, DATA_W+1 bits wide (data plus last), FIFO_DEPTH entries.
  - ports: push, pop, count, empty, full.
  - async active-low reset; registered head output.
- The top level holds the FSM, address and remaining counters, inflight register and credit logic.

Test Plan:
- Basic run: base_addr=0x0010, word_count=4, out_ready=1, memory preloaded with data=address -> mem_address 0x10..0x13 on consecutive cycles. out_data 0x10..0x13, first out_valid 2 cycles after the first issue. out_last only on 0x13. One done pulse; busy then drops.
- Backpressure: word_count=10, out_ready=0 for 20 cycles then 1 -> exactly FIFO_DEPTH=4 reads issued before stall. No data lost or duplicated. All 10 words delivered in order.
- Wrap: base_addr=0xFFFE, word_count=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001. Data order matches.
- Zero count: start with word_count=0 -> no mem_clken ever. done pulses 2 cycles after start. out_valid stays 0.
- Start ignored and reset mid-run: a second start while busy (word_count=3) does not change the address sequence. reset_n low mid-transfer -> busy, out_valid and mem_clken go to 0 immediately. A new start after release runs cleanly from its own base_addr.
- Random out_ready toggling (50%) over word_count=1000 -> scoreboard confirms all 1000 words in order. Exactly one out_last. mem_clken never asserted while fifo_count + inflight == 4.

Source files
------------

// File: rtl/ocm_pkg.sv
// Shared types and constants for the on-chip-memory scanout reader.
package ocm_pkg;

   localparam int OCM_ADDR_W = 16;
   localparam int OCM_DATA_W = 32;
   localparam int OCM_DEPTH  = 65536;

   // Reader control states.
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FIN
   } state_t;

endpackage

// File: rtl/ocm_stream_fifo.sv
// Small synchronous FIFO carrying {last, data} between memory capture and
// the output stream. The head entry is read straight from the storage flops.
module ocm_stream_fifo
   import ocm_pkg::*;
#(
   parameter int WIDTH = OCM_DATA_W + 1,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Storage, pointers and occupancy; push and pop together keep count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: this storage is a handful of flops, so it is reset to give a
         // defined all-zero head after reset; a large RAM would not be.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/ocm_scanout_reader.sv
// Streaming read engine: issues sequential word reads from on-chip memory,
// captures each word one cycle after issue and forwards it through a
// credit-controlled FIFO onto a valid/ready stream.
module ocm_scanout_reader
   import ocm_pkg::*;
#(
   parameter int ADDR_W     = OCM_ADDR_W,
   parameter int DATA_W     = OCM_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 17
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  remaining;
   logic              inflight_v;
   logic              inflight_last;
   logic              done_q;
   logic              accept;
   logic              issue;
   logic              pop;
   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic [DATA_W:0]   head;

   // A start is only honoured when fully idle, including the done cycle.
   assign accept = start && (state == IDLE) && !done_q;

   // Credit: FIFO occupancy plus the read in flight must leave a free slot.
   assign issue = (state == RUN) && (remaining != '0) && !fifo_full &&
                  ((fifo_count + CW'(inflight_v)) < CW'(FIFO_DEPTH));

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         // NOTE: all clocked state uses non-blocking assignments so every
         // register samples pre-edge values, independent of statement order.
         state <= state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so every path assigns state_nx and no latch forms.
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (word_count != '0) ? RUN : FIN;
         RUN:     if (remaining == '0) state_nx = DRAIN;
         DRAIN:   if (fifo_empty && !inflight_v) state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Address/remaining counters, in-flight capture tag and done pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q        <= '0;
         remaining     <= '0;
         inflight_v    <= 1'b0;
         inflight_last <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         done_q        <= (state == FIN);
         inflight_v    <= issue;
         inflight_last <= issue && (remaining == CNT_W'(1));
         if (accept && (word_count != '0)) begin
            addr_q    <= base_addr;
            remaining <= word_count;
         end else if (issue) begin
            addr_q    <= addr_q + 1'b1;
            remaining <= remaining - 1'b1;
         end
      end
   end

   ocm_stream_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (inflight_v),
      .push_data ({inflight_last, mem_readdata}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign pop         = out_valid && out_ready;
   assign out_valid   = !fifo_empty;
   assign out_data    = head[DATA_W-1:0];
   assign out_last    = out_valid && head[DATA_W];
   assign mem_clken   = issue;
   assign mem_address = addr_q;
   assign done        = done_q;
   assign busy        = (state != IDLE) || done_q;

endmodule

// File: tb/tb_ocm_scanout_reader.sv
// Directed bench for ocm_scanout_reader with a data=address memory model and
// an in-order scoreboard on the output stream.
module tb_ocm_scanout_reader;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [15:0] base_addr;
   logic [16:0] word_count;
   logic        busy;
   logic        done;
   logic [15:0] mem_address;
   logic        mem_clken;
   logic [31:0] mem_readdata;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   ocm_scanout_reader dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .base_addr    (base_addr),
      .word_count   (word_count),
      .busy         (busy),
      .done         (done),
      .mem_address  (mem_address),
      .mem_clken    (mem_clken),
      .mem_readdata (mem_readdata),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: q = zero-extended address, updated only when enabled.
   initial mem_readdata = 32'h0;
   always @(posedge clk) begin
      if (mem_clken) mem_readdata <= {16'h0, mem_address};
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          ready_mode = 1;
   logic        mon_on   = 1'b0;
   logic [15:0] exp_base = 16'h0;
   int          exp_cnt, issue_idx, pop_idx, last_cnt, done_cnt, valid_seen;
   int          start_cyc, first_issue_cyc, first_valid_cyc, done_cyc;
   logic        prev_done  = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = 32'h0;
   logic        prev_last  = 1'b0;
   logic        done_now   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One cycle: apply out_ready for the coming edge, then sample at negedge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      done_now = done;
      if (prev_done) check("busy_after_done", {31'h0, busy}, 32'h0);
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         check("busy_at_done", {31'h0, busy}, 32'h1);
      end
      prev_done = done;
      if (mon_on) begin
         if (prev_stall) begin
            check("hold_valid", {31'h0, out_valid}, 32'h1);
            check("hold_data", out_data, prev_data);
            check("hold_last", {31'h0, out_last}, {31'h0, prev_last});
         end
         if (mem_clken) begin
            if (first_issue_cyc < 0) first_issue_cyc = cyc;
            check("issue_in_range", 32'(issue_idx < exp_cnt), 32'h1);
            check("credit", 32'((issue_idx - pop_idx) < 4), 32'h1);
            check("addr", {16'h0, mem_address}, {16'h0, exp_base + 16'(issue_idx)});
            issue_idx++;
         end
         if (out_valid) begin
            valid_seen++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            check("data", out_data, {16'h0, exp_base + 16'(pop_idx)});
            check("last", {31'h0, out_last}, 32'(pop_idx == exp_cnt - 1));
            if (out_last) last_cnt++;
            pop_idx++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   endtask

   task automatic start_xfer(input logic [15:0] b, input int n);
      exp_base = b; exp_cnt = n;
      issue_idx = 0; pop_idx = 0; last_cnt = 0; done_cnt = 0; valid_seen = 0;
      first_issue_cyc = -1; first_valid_cyc = -1;
      prev_stall = 1'b0; mon_on = 1'b1;
      base_addr = b; word_count = 17'(n); start = 1'b1; start_cyc = cyc;
      tick();
      start = 1'b0;
      check("busy_after_start", {31'h0, busy}, 32'h1);
   endtask

   task automatic run_until_done(input int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         tick();
         if (done_now) got = 1'b1;
      end
      check("done_timeout", {31'h0, got}, 32'h1);
      if (got) tick();
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; base_addr = 16'h0; word_count = 17'h0;
      out_ready = 1'b1;
      tick(); tick();
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_addr", {16'h0, mem_address}, 32'h0);
      check("rst_clken", {31'h0, mem_clken}, 32'h0);
      check("rst_valid", {31'h0, out_valid}, 32'h0);
      check("rst_last", {31'h0, out_last}, 32'h0);
      check("rst_data", out_data, 32'h0);
      reset_n = 1'b1;
      tick();

      // Basic run.
      ready_mode = 1;
      start_xfer(16'h0010, 4);
      run_until_done(100);
      check("basic_issues", 32'(issue_idx), 32'd4);
      check("basic_words", 32'(pop_idx), 32'd4);
      check("basic_lasts", 32'(last_cnt), 32'd1);
      check("basic_dones", 32'(done_cnt), 32'd1);
      check("basic_issue_lat", 32'(first_issue_cyc - start_cyc), 32'd1);
      check("basic_valid_lat", 32'(first_valid_cyc - first_issue_cyc), 32'd2);

      // Backpressure.
      ready_mode = 0;
      start_xfer(16'h0020, 10);
      repeat (20) tick();
      check("bp_issues_stalled", 32'(issue_idx), 32'd4);
      check("bp_valid", {31'h0, out_valid}, 32'h1);
      check("bp_head", out_data, 32'h0000_0020);
      ready_mode = 1;
      run_until_done(100);
      check("bp_words", 32'(pop_idx), 32'd10);
      check("bp_lasts", 32'(last_cnt), 32'd1);
      check("bp_dones", 32'(done_cnt), 32'd1);

      // Address wrap.
      start_xfer(16'hFFFE, 4);
      run_until_done(100);
      check("wrap_issues", 32'(issue_idx), 32'd4);
      check("wrap_words", 32'(pop_idx), 32'd4);
      check("wrap_lasts", 32'(last_cnt), 32'd1);

      // Zero count.
      start_xfer(16'h0123, 0);
      run_until_done(20);
      check("zero_issues", 32'(issue_idx), 32'd0);
      check("zero_valid", 32'(valid_seen), 32'd0);
      check("zero_done_lat", 32'(done_cyc - start_cyc), 32'd2);
      check("zero_dones", 32'(done_cnt), 32'd1);

      // Second start while busy is ignored.
      start_xfer(16'h0100, 8);
      tick();
      base_addr = 16'h0300; word_count = 17'd3; start = 1'b1;
      tick();
      start = 1'b0;
      run_until_done(100);
      check("ign_issues", 32'(issue_idx), 32'd8);
      check("ign_words", 32'(pop_idx), 32'd8);
      check("ign_dones", 32'(done_cnt), 32'd1);

      // Reset mid-transfer, then a clean restart.
      ready_mode = 0;
      start_xfer(16'h0500, 20);
      repeat (6) tick();
      mon_on = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'h0, busy}, 32'h0);
      check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
      check("mid_rst_clken", {31'h0, mem_clken}, 32'h0);
      check("mid_rst_data", out_data, 32'h0);
      tick(); tick();
      reset_n = 1'b1;
      tick(); tick();
      check("mid_rst_no_done", 32'(done_cnt), 32'd0);
      ready_mode = 1;
      start_xfer(16'h0600, 5);
      run_until_done(100);
      check("restart_words", 32'(pop_idx), 32'd5);
      check("restart_lasts", 32'(last_cnt), 32'd1);
      check("restart_dones", 32'(done_cnt), 32'd1);

      // Random backpressure over a long transfer that also wraps.
      ready_mode = 2;
      start_xfer(16'hFF00, 1000);
      run_until_done(20000);
      check("rand_issues", 32'(issue_idx), 32'd1000);
      check("rand_words", 32'(pop_idx), 32'd1000);
      check("rand_lasts", 32'(last_cnt), 32'd1);
      check("rand_dones", 32'(done_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
